bldc_gatedrv_dt: RTL and testbench

BLDC_GATEDRV_DT -- requirements
Module: bldc_gatedrv_dt

---
 rtl/bldc_gd_pkg.sv | 27 ++
 rtl/bldc_gatedrv_dt_phase.sv | 32 +++
 rtl/bldc_gatedrv_dt.sv | 72 +++++++
 tb/tb_bldc_gatedrv_dt.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/bldc_gd_pkg.sv
// bldc_gd_pkg: shared states, gate encodings and hall commutation table
package bldc_gd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BRAKE = 2'd2, FAULT = 2'd3} state_t;
  localparam logic [1:0] COAST = 2'b00;
  localparam logic [1:0] LOW_ON = 2'b01;
  localparam logic [1:0] HIGH_ON = 2'b10;
  typedef struct packed {
    logic valid;
    logic [1:0] hi;
    logic [1:0] lo;
  } comm_t;
  // Phase indices: 0=A, 1=B, 2=C; reverse swaps the high and low phases
  function automatic comm_t commutate(input logic [2:0] h, input logic d);
    comm_t c;
    case (h)
      3'b101: c = {1'b1, 2'd0, 2'd1};
      3'b100: c = {1'b1, 2'd0, 2'd2};
      3'b110: c = {1'b1, 2'd1, 2'd2};
      3'b010: c = {1'b1, 2'd1, 2'd0};
      3'b011: c = {1'b1, 2'd2, 2'd0};
      3'b001: c = {1'b1, 2'd2, 2'd1};
      default: c = {1'b0, 2'd0, 2'd0};
    endcase
    if (d) c = {c.valid, c.lo, c.hi};
    return c;
  endfunction
endpackage

// File: rtl/bldc_gatedrv_dt_phase.sv
// bldc_phase_deadtime: per-phase shoot-through guard with instant turn-off and delayed turn-on
module bldc_phase_deadtime
  import bldc_gd_pkg::*;
#(
  parameter int DEADTIME = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gate
);
  localparam logic [7:0] DT = 8'(DEADTIME);
  logic [7:0] off_hi, off_lo;
  logic [1:0] nxt;
  // A switch may be on only if requested alone and its complement has been off long enough
  always_comb begin
    nxt[1] = req[1] && !req[0] && off_lo == DT;
    nxt[0] = req[0] && !req[1] && off_hi == DT;
  end
  // Off-counters track the outgoing gate so this cycle's turn-off already counts
  always_ff @(posedge clk) begin
    if (rst) begin
      gate <= COAST;
      off_hi <= DT;
      off_lo <= DT;
    end else begin
      gate <= nxt;
      off_hi <= nxt[1] ? 8'd0 : off_hi == DT ? DT : off_hi + 8'd1;
      off_lo <= nxt[0] ? 8'd0 : off_lo == DT ? DT : off_lo + 8'd1;
    end
  end
endmodule

// File: rtl/bldc_gatedrv_dt.sv
// bldc_gatedrv_dt: hall-commutated three-phase gate driver with fault FSM and dead-time guards
module bldc_gatedrv_dt
  import bldc_gd_pkg::*;
#(
  parameter int DEADTIME = 8,
  parameter int HALL_STABLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pwm,
  input  logic       dir,
  input  logic       brake,
  input  logic [2:0] hall,
  input  logic       fault_clr,
  output logic [1:0] gate_a,
  output logic [1:0] gate_b,
  output logic [1:0] gate_c,
  output logic       fault,
  output logic [1:0] state
);
  localparam logic [7:0] HS = 8'(HALL_STABLE);
  logic [2:0] sync1, sync2, cand, hall_filt;
  logic [7:0] cnt;
  state_t st, nxt;
  comm_t cm;
  logic [1:0] g [3];
  // Synchronise hall, then accept a code only once it has held HALL_STABLE cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 3'b101;
      sync2 <= 3'b101;
      cand <= 3'b101;
      cnt <= 8'd0;
      hall_filt <= 3'b101;
    end else begin
      sync1 <= hall;
      sync2 <= sync1;
      cand <= sync2;
      cnt <= sync2 != cand ? 8'd1 : cnt == HS ? HS : cnt + 8'd1;
      if (cnt == HS) hall_filt <= cand;
    end
  end
  // Next state drives both the state register and the gate requests so they line up
  always_comb begin
    cm = commutate(hall_filt, dir);
    nxt = !cm.valid ? FAULT : st == FAULT ? (fault_clr ? IDLE : FAULT) :
          brake ? BRAKE : enable ? RUN : IDLE;
  end
  // State and fault flag registered alongside the guarded gates
  always_ff @(posedge clk) begin
    st <= rst ? IDLE : nxt;
    fault <= !rst && nxt == FAULT;
  end
  for (genvar i = 0; i < 3; i++) begin : g_ph
    logic [1:0] r;
    assign r = nxt == BRAKE ? LOW_ON :
               nxt != RUN ? COAST :
               cm.hi == 2'(i) ? {pwm, 1'b0} :
               cm.lo == 2'(i) ? LOW_ON : COAST;
    bldc_phase_deadtime #(.DEADTIME(DEADTIME)) u_dt (
      .clk(clk),
      .rst(rst),
      .req(r),
      .gate(g[i])
    );
  end
  assign gate_a = g[0];
  assign gate_b = g[1];
  assign gate_c = g[2];
  assign state = st;
endmodule

// File: tb/tb_bldc_gatedrv_dt.sv
// tb_bldc_gatedrv_dt: scoreboard bench for the gate driver at DEADTIME=4, HALL_STABLE=3
module tb_bldc_gatedrv_dt;
  logic clk = 1'b0;
  logic rst, enable, pwm, dir, brake, fault_clr;
  logic [2:0] hall;
  logic [1:0] gate_a, gate_b, gate_c, state;
  logic fault;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  logic seen11 = 1'b0;
  typedef struct {
    int at;
    string tag;
    logic [8:0] v;
  } exp_t;
  exp_t sb[$];
  localparam logic [8:0] V_IDLE = 9'b00_0_00_00_00;
  localparam logic [8:0] V_FLT = 9'b11_1_00_00_00;
  localparam logic [8:0] V_AB = 9'b01_0_10_01_00;
  localparam logic [8:0] V_AC = 9'b01_0_10_00_01;
  localparam logic [8:0] V_OFF = 9'b01_0_00_00_00;
  bldc_gatedrv_dt #(.DEADTIME(4), .HALL_STABLE(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pwm(pwm), .dir(dir), .brake(brake),
    .hall(hall), .fault_clr(fault_clr), .gate_a(gate_a), .gate_b(gate_b),
    .gate_c(gate_c), .fault(fault), .state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask
  task automatic push(input int off, input string tag, input logic [8:0] v);
    sb.push_back('{cyc + off, tag, v});
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (gate_a == 2'b11 || gate_b == 2'b11 || gate_c == 2'b11) seen11 <= 1'b1;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].at == cyc) begin
        chk(sb[i].tag, {state, fault, gate_a, gate_b, gate_c}, sb[i].v);
        sb.delete(i);
      end
  end
  initial begin
    rst = 1'b1; enable = 1'b0; pwm = 1'b0; dir = 1'b0; brake = 1'b0;
    fault_clr = 1'b0; hall = 3'b101;
    push(1, "reset", V_IDLE);
    tick(2);
    rst = 1'b0; enable = 1'b1; pwm = 1'b1;
    push(1, "run_first", V_AB);
    push(10, "run_settled", V_AB);
    tick(12);
    hall = 3'b100;
    push(6, "pre_comm", V_AB);
    push(7, "comm_c_on", V_AC);
    tick(10);
    hall = 3'b101;
    push(6, "pre_back", V_AC);
    push(7, "back_101", V_AB);
    tick(10);
    hall = 3'b100;
    for (int k = 3; k <= 9; k += 2) push(k, "glitch", V_AB);
    tick(2);
    hall = 3'b101;
    tick(8);
    dir = 1'b1;
    push(1, "dir_off", V_OFF);
    push(4, "dir_guard", V_OFF);
    push(5, "dir_on", 9'b01_0_01_10_00);
    tick(8);
    dir = 1'b0;
    push(1, "dirb_off", V_OFF);
    push(4, "dirb_guard", V_OFF);
    push(5, "dirb_on", V_AB);
    tick(8);
    brake = 1'b1; pwm = 1'b0;
    push(1, "brake_enter", 9'b10_0_00_01_01);
    push(4, "brake_guard", 9'b10_0_00_01_01);
    push(5, "brake_all_low", 9'b10_0_01_01_01);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      pwm = ~pwm;
    end
    brake = 1'b0; pwm = 1'b1;
    push(1, "unbrake", 9'b01_0_00_01_00);
    push(4, "unbrake_guard", 9'b01_0_00_01_00);
    push(5, "unbrake_on", V_AB);
    tick(6);
    hall = 3'b000;
    push(6, "pre_fault", V_AB);
    push(7, "fault_000", V_FLT);
    tick(9);
    fault_clr = 1'b1; brake = 1'b1;
    push(1, "clr_ignored", V_FLT);
    tick(1);
    fault_clr = 1'b0; brake = 1'b0; hall = 3'b101;
    push(6, "fault_hold", V_FLT);
    tick(7);
    fault_clr = 1'b1;
    push(1, "clr_ok", V_IDLE);
    tick(1);
    fault_clr = 1'b0;
    push(1, "rerun", V_AB);
    tick(2);
    hall = 3'b111;
    push(6, "pre_fault_111", V_AB);
    push(7, "fault_111", V_FLT);
    tick(6);
    fault_clr = 1'b1;
    push(1, "clr_with_111", V_FLT);
    tick(1);
    fault_clr = 1'b0; hall = 3'b101;
    push(1, "still_fault", V_FLT);
    push(6, "hold_111", V_FLT);
    tick(7);
    fault_clr = 1'b1;
    push(1, "clr_111_ok", V_IDLE);
    tick(1);
    fault_clr = 1'b0;
    push(1, "rerun_111", V_AB);
    tick(2);
    rst = 1'b1;
    push(1, "rst_mid", V_IDLE);
    tick(1);
    rst = 1'b0;
    push(1, "post_rst_run", V_AB);
    tick(3);
    chk("never_11", 9'(seen11), 9'd0);
    chk("sb_drain", 9'(sb.size()), 9'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
